// File: rtl/rom_bus_ctrl_if.sv
// CPU-side single-word read bus into the boot-ROM controller.
// The requester holds req and addr stable until ack or err.
interface rom_bus_ctrl_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] data;
  logic        ack;
  logic        err;

  modport master (output req, we, addr, input data, ack, err);
  modport slave  (input req, we, addr, output data, ack, err);
endinterface

// File: rtl/rom_bus_ctrl.sv
// Boot-ROM bus controller: decodes the boot window, drives the ROM
// CE/address handshake and returns data with a one-cycle ack or err.
//
// state   | meaning
// IDLE    | wait for a request; legality checked here only
// ISSUE   | CE and address presented, ROM samples
// CAPTURE | wait for rom_ready, bounded by TIMEOUT
// DONE    | ack pulse with read data
// ERR     | err pulse
module rom_bus_ctrl #(
  parameter logic [31:0] ROM_BASE = 32'hBFC00000,
  parameter int          ROM_AW   = 12,
  parameter int          TIMEOUT  = 8
) (
  input  logic              clk,
  input  logic              rst,
  rom_bus_ctrl_if.slave     bus,
  output logic [ROM_AW-1:0] rom_addr,
  output logic              rom_ce,
  output logic              rom_we,
  input  logic [31:0]       rom_data,
  input  logic              rom_ready
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_SAT  = CW'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, DONE, ERR} state_t;

  state_t            state, state_nx;
  logic [31:0]       data_q, data_nx;
  logic              ack_q, ack_nx;
  logic              err_q, err_nx;
  logic [ROM_AW-1:0] addr_q, addr_nx;
  logic              ce_q, ce_nx;
  logic [CW-1:0]     cnt_q, cnt_nx;
  logic              legal;

  assign legal = !bus.we && (bus.addr[1:0] == 2'b00) &&
                 (bus.addr[31:ROM_AW] == ROM_BASE[31:ROM_AW]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      data_q <= '0;
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      addr_q <= '0;
      ce_q   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      state  <= state_nx;
      data_q <= data_nx;
      ack_q  <= ack_nx;
      err_q  <= err_nx;
      addr_q <= addr_nx;
      ce_q   <= ce_nx;
      cnt_q  <= cnt_nx;
    end
  end

  // ack/err and read data are single-cycle, so they default to zero every cycle
  always_comb begin
    state_nx = state;
    data_nx  = '0;
    ack_nx   = 1'b0;
    err_nx   = 1'b0;
    addr_nx  = addr_q;
    ce_nx    = ce_q;
    cnt_nx   = cnt_q;
    case (state)
      IDLE: begin
        if (bus.req) begin
          if (legal) begin
            addr_nx  = bus.addr[ROM_AW-1:0];
            ce_nx    = 1'b1;
            cnt_nx   = '0;
            state_nx = ISSUE;
          end else begin
            err_nx   = 1'b1;
            state_nx = ERR;
          end
        end
      end
      ISSUE: state_nx = CAPTURE;
      CAPTURE: begin
        if (rom_ready) begin
          data_nx  = rom_data;
          ack_nx   = 1'b1;
          ce_nx    = 1'b0;
          state_nx = DONE;
        end else if (cnt_q == CNT_LAST) begin
          cnt_nx   = CNT_SAT;
          ce_nx    = 1'b0;
          err_nx   = 1'b1;
          state_nx = ERR;
        end else begin
          cnt_nx = cnt_q + CW'(1);
        end
      end
      DONE:    state_nx = IDLE;
      ERR:     state_nx = IDLE;
      default: begin
        ce_nx    = 1'b0;
        state_nx = IDLE;
      end
    endcase
  end

  assign bus.data = data_q;
  assign bus.ack  = ack_q;
  assign bus.err  = err_q;
  assign rom_addr = addr_q;
  assign rom_ce   = ce_q;
  assign rom_we   = 1'b0;

endmodule

// File: tb/tb_rom_bus_ctrl.sv
// Bench for rom_bus_ctrl: transaction-level schedule model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_rom_bus_ctrl;
  localparam int T = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rom_bus_ctrl_if bus ();
  logic [11:0] rom_addr;
  logic        rom_ce, rom_we;
  logic [31:0] rom_data  = '0;
  logic        rom_ready = 1'b0;
  logic        rom_hold  = 1'b0;
  logic [31:0] mem [0:1023];

  int n_vec = 0;
  int n_err = 0;

  rom_bus_ctrl #(.ROM_BASE(32'hBFC00000), .ROM_AW(12), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .rom_addr(rom_addr), .rom_ce(rom_ce), .rom_we(rom_we),
    .rom_data(rom_data), .rom_ready(rom_ready)
  );

  // Registered ROM; while deselected its ready line carries random noise
  always @(posedge clk) begin
    rom_ready <= rom_ce ? !rom_hold : 1'($urandom_range(0, 1));
    rom_data  <= mem[rom_addr[11:2]];
  end

  // Model: each accepted request fixes the cycles of its CE window and its ack/err
  int cyc = 0;
  int next_free = 0;
  int ce_from = -1, ce_to = -2, ack_cyc = -1, err_cyc = -1, addr_cyc = 0;
  logic [31:0] ack_data = '0;
  logic [11:0] addr_prev = '0, addr_cur = '0;

  always @(posedge clk) begin
    if (!rst) begin
      next_free = 0; ce_from = -1; ce_to = -2; ack_cyc = -1; err_cyc = -1;
      addr_prev = '0; addr_cur = '0; addr_cyc = 0;
    end else if (bus.req && cyc >= next_free) begin
      if (!bus.we && bus.addr[1:0] == 2'b00 && bus.addr[31:12] == 20'hBFC00) begin
        addr_prev = addr_cur;
        addr_cur  = bus.addr[11:0];
        addr_cyc  = cyc + 1;
        ce_from   = cyc + 1;
        if (!rom_hold) begin
          ce_to = cyc + 2; ack_cyc = cyc + 3; next_free = cyc + 4;
          ack_data = mem[bus.addr[11:2]];
        end else begin
          ce_to = cyc + 1 + T; err_cyc = cyc + 2 + T; next_free = cyc + 3 + T;
        end
      end else begin
        err_cyc = cyc + 1; next_free = cyc + 2;
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    logic [47:0] act, exp;
    logic e_ack;
    act = {bus.data, bus.ack, bus.err, rom_ce, rom_we, rom_addr};
    e_ack = (cyc == ack_cyc);
    if (!rst) exp = '0;
    else exp = {e_ack ? ack_data : 32'h0, e_ack, (cyc == err_cyc),
                (cyc >= ce_from && cyc <= ce_to), 1'b0,
                (cyc >= addr_cyc) ? addr_cur : addr_prev};
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL cycle %0d {data,ack,err,ce,we,addr}: got %h expected %h", cyc, act, exp);
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic nclk(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start(logic we, logic [31:0] a);
    bus.req = 1'b1; bus.we = we; bus.addr = a;
  endtask

  initial begin
    logic [31:0] a;
    int k;
    logic [31:0] ill_addr [3];
    logic        ill_we [3];
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[0] = 32'h11111111; mem[2] = 32'h22222222; mem[3] = 32'h33333333;
    mem[4] = 32'h3C1DBFC0; mem[1023] = 32'hDEADBEEF;
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0;
    #1 rst = 1'b0;
    nclk(3);
    chk("reset outputs", {bus.data[29:0], bus.ack, bus.err} | {31'h0, rom_ce | rom_we}, 32'h0);
    chk("reset rom_addr", 32'(rom_addr), 32'h0);
    #2 rst = 1'b1;

    // Single read
    nclk(1); start(1'b0, 32'hBFC00010);
    nclk(1); chk("rd ce N+1", 32'(rom_ce), 32'h1); chk("rd addr", 32'(rom_addr), 32'h010);
    nclk(1); chk("rd ce N+2", 32'(rom_ce), 32'h1);
    nclk(1); chk("rd ack N+3", 32'(bus.ack), 32'h1); chk("rd data", bus.data, 32'h3C1DBFC0);
    chk("rd ce N+3", 32'(rom_ce), 32'h0);
    bus.req = 1'b0;

    // Back-to-back with req held through DONE
    nclk(1); start(1'b0, 32'hBFC00000);
    nclk(3); chk("b2b ack0", 32'(bus.ack), 32'h1); chk("b2b data0", bus.data, 32'h11111111);
    bus.addr = 32'hBFC00FFC;
    nclk(1); chk("b2b DONE ignores req", 32'(rom_ce), 32'h0);
    nclk(3); chk("b2b ack1", 32'(bus.ack), 32'h1); chk("b2b data1", bus.data, 32'hDEADBEEF);
    bus.req = 1'b0;

    // Illegal accesses
    ill_addr[0] = 32'hBFC00000; ill_we[0] = 1'b1;
    ill_addr[1] = 32'hBFC00002; ill_we[1] = 1'b0;
    ill_addr[2] = 32'h80000000; ill_we[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nclk(1); start(ill_we[i], ill_addr[i]);
      nclk(1); chk("illegal err N+1", 32'(bus.err), 32'h1);
      chk("illegal data", bus.data, 32'h0); chk("illegal ce", 32'(rom_ce), 32'h0);
      bus.req = 1'b0; bus.we = 1'b0;
    end

    // Timeout with ROM never ready
    nclk(2); rom_hold = 1'b1;
    nclk(1); start(1'b0, 32'hBFC00004);
    k = 0;
    while (k < 30) begin
      nclk(1); k++;
      if (bus.err) break;
    end
    chk("timeout err cycle", 32'(k), 32'd10);
    chk("timeout ce fell", 32'(rom_ce), 32'h0);
    bus.req = 1'b0;
    nclk(2); rom_hold = 1'b0;

    // Reset during CAPTURE
    nclk(1); start(1'b0, 32'hBFC00008);
    nclk(2); #2 rst = 1'b0;
    #1 chk("async reset outputs", {bus.data[28:0], bus.ack, bus.err, rom_ce}, 32'h0);
    chk("async reset addr", 32'(rom_addr), 32'h0);
    bus.req = 1'b0;
    nclk(2); #2 rst = 1'b1;
    nclk(1); start(1'b0, 32'hBFC00008);
    nclk(3); chk("post-reset ack", 32'(bus.ack), 32'h1); chk("post-reset data", bus.data, 32'h22222222);
    bus.req = 1'b0;

    // Request dropped during ISSUE
    nclk(1); start(1'b0, 32'hBFC0000C);
    nclk(1); bus.req = 1'b0;
    nclk(2); chk("drop ack", 32'(bus.ack), 32'h1); chk("drop data", bus.data, 32'h33333333);
    nclk(3);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      nclk(1);
      if (bus.req) begin
        if (bus.ack || bus.err || $urandom_range(0, 15) == 0) bus.req = 1'b0;
      end else if (cyc >= next_free && $urandom_range(0, 5) == 0) begin
        rom_hold = ($urandom_range(0, 7) == 0);
      end else if ($urandom_range(0, 2) == 0) begin
        a = {20'hBFC00, 10'($urandom_range(0, 1023)), 2'b00};
        case ($urandom_range(0, 9))
          0: start(1'b1, a);
          1: start(1'b0, a | 32'($urandom_range(1, 3)));
          2: begin a = $urandom; a[31:28] = 4'h3; start(1'b0, a); end
          default: start(1'b0, a);
        endcase
      end
    end
    bus.req = 1'b0;
    nclk(T + 6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
